// File: rtl/input_event_sync.sv
// -----------------------------------------------------------------------------
// input_event_sync
//
// Purpose:
//   N-channel front end for the player "flap" inputs (mouse button, UART
//   remote click, pushbuttons). Each channel gets its own synchroniser,
//   debouncer, edge detector, post-event holdoff and saturating event
//   counter. It lives in the pixel-clock domain and feeds game_fsm.
//
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset
//   in_async   raw asynchronous channel inputs, one bit per channel
//   ch_en      per-channel pulse enable (synchronous)
//   edge_mode  00 rise, 01 fall, 10 both, 11 none (shared by all channels)
//   cnt_clr    synchronous clear of all event counters
//   level      debounced stable level per channel
//   pulse      one-cycle event pulse per channel
//   any_pulse  OR of pulse, same cycle
//   event_cnt  saturating pulse counts, channel i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module input_event_sync #(
    parameter int N_CH         = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 650000,
    parameter int HOLDOFF_CYC  = 0,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         in_async,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [1:0]              edge_mode,
    input  logic                    cnt_clr,
    output logic [N_CH-1:0]         level,
    output logic [N_CH-1:0]         pulse,
    output logic                    any_pulse,
    output logic [N_CH*CNT_W-1:0]   event_cnt
);

    localparam int DB_W = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int HO_W = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_NONE = 2'b11
    } edge_mode_e;

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  sync_d [SYNC_STAGES];
    logic [N_CH-1:0]  sync_w;

    logic [N_CH-1:0]  prev_q, prev_d;
    logic [N_CH-1:0]  pulse_q, pulse_d;
    logic [N_CH-1:0]  rise_w, fall_w, match_w;
    logic [HO_W-1:0]  ho_q [N_CH];
    logic [HO_W-1:0]  ho_d [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    edge_mode_e mode_w;
    assign mode_w = edge_mode_e'(edge_mode);

    // The synchroniser is a plain shift chain: stage 0 samples the raw
    // inputs, every later stage copies the one before it. Only the last
    // stage is ever looked at by the rest of the block.
    always_comb begin
        sync_d[0] = in_async;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Synchroniser registers, cleared on reset so a held-high input has to
    // travel the whole chain and re-qualify afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Debouncer. With DEBOUNCE_CYC == 0 the level is simply the synchroniser
    // output, so no extra register stage is added. Otherwise each channel
    // counts consecutive cycles where the synchronised input disagrees with
    // the accepted level; any agreement restarts the count, so a glitch
    // shorter than DEBOUNCE_CYC cycles can never reach the threshold.
    generate
        if (DEBOUNCE_CYC == 0) begin : g_db_bypass
            assign level = sync_w;
        end else begin : g_db
            logic [N_CH-1:0] level_q, level_d;
            logic [DB_W-1:0] db_cnt_q [N_CH];
            logic [DB_W-1:0] db_cnt_d [N_CH];

            // Next-state for level and the per-channel stability counters.
            always_comb begin
                level_d = level_q;
                for (int i = 0; i < N_CH; i++) begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                    if (sync_w[i] == level_q[i]) begin
                        db_cnt_d[i] = '0;
                    end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                        level_d[i]  = sync_w[i];
                        db_cnt_d[i] = '0;
                    end
                end
            end

            // Level and counter registers; reset drops any pending debounce.
            always_ff @(posedge clk) begin
                if (rst) begin
                    level_q <= '0;
                    for (int i = 0; i < N_CH; i++) begin
                        db_cnt_q[i] <= '0;
                    end
                end else begin
                    level_q <= level_d;
                    for (int i = 0; i < N_CH; i++) begin
                        db_cnt_q[i] <= db_cnt_d[i];
                    end
                end
            end

            assign level = level_q;
        end
    endgenerate

    // Edge detection works on the registered level against a one-cycle
    // delayed copy, so a pulse appears the cycle after level changes.
    // A pulse needs a matching edge, the channel enabled right now, and no
    // holdoff running. Edges during holdoff are simply lost. The holdoff
    // counter is loaded together with the pulse and then counts down.
    always_comb begin
        prev_d  = level;
        rise_w  = level & ~prev_q;
        fall_w  = ~level & prev_q;
        match_w = '0;
        pulse_d = '0;
        unique case (mode_w)
            MODE_RISE: match_w = rise_w;
            MODE_FALL: match_w = fall_w;
            MODE_BOTH: match_w = rise_w | fall_w;
            MODE_NONE: match_w = '0;
            default:   match_w = '0;
        endcase
        for (int i = 0; i < N_CH; i++) begin
            pulse_d[i] = match_w[i] & ch_en[i] & (ho_q[i] == '0);
            if (pulse_d[i]) begin
                ho_d[i] = HO_W'(HOLDOFF_CYC);
            end else if (ho_q[i] != '0) begin
                ho_d[i] = ho_q[i] - HO_W'(1);
            end else begin
                ho_d[i] = ho_q[i];
            end
        end
    end

    // Event counters saturate at all-ones; a clear beats an increment that
    // lands in the same cycle.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (pulse_q[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge history, pulse, holdoff and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ho_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_CH; i++) begin
                ho_q[i]  <= ho_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pulse     = pulse_q;
    assign any_pulse = |pulse_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
        assign event_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule
